// File: rtl/tcm_lsu_bridge.sv
// ============================================================================
// Module      : tcm_lsu_bridge
// Description : LSU-to-TCM bridge with in-order, credit-limited response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcm_lsu_bridge #(
   parameter int ADDR_WIDTH = 15,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  tcm_en_o,
   output logic [ADDR_WIDTH-1:0] tcm_addr_o,
   output logic                  tcm_we_o,
   output logic [3:0]            tcm_be_o,
   output logic [31:0]           tcm_wdata_o,
   input  logic [31:0]           tcm_rdata_i
);

   localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);

   // Request side
   logic                 w_accept;
   logic                 w_misaligned;
   logic                 w_store;
   logic                 w_pop;
   logic                 w_push;
   logic [c_CNT_W:0]     w_used;
   logic [3:0]           w_be_base;
   logic [31:0]          w_wdata_rep;

   // In-flight stage
   logic                 r_inf_valid;
   logic                 r_inf_we;
   logic [1:0]           r_inf_size;
   logic                 r_inf_uns;
   logic [1:0]           r_inf_off;
   logic                 r_inf_err;

   // Response computation
   logic [31:0]          w_shifted;
   logic [31:0]          w_load;
   logic [31:0]          w_rsp_data;

   // Response FIFO
   logic [31:0]          r_data [RSP_DEPTH];
   logic                 r_err  [RSP_DEPTH];
   logic [c_PTR_W-1:0]   r_wr;
   logic [c_PTR_W-1:0]   r_rd;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_PTR_W-1:0]   w_wr_nxt;
   logic [c_PTR_W-1:0]   w_rd_nxt;

   // A credit is held from accept until the response pops; a same-cycle pop frees one.
   assign w_pop       = rsp_valid_o & rsp_ready_i;
   assign w_used      = {{c_CNT_W{1'b0}}, r_inf_valid} + {1'b0, r_count};
   assign req_ready_o = !rst_i &&
                        ((w_used - {{c_CNT_W{1'b0}}, w_pop}) < (c_CNT_W+1)'(RSP_DEPTH));
   assign w_accept    = req_valid_i & req_ready_o;

   always_comb begin
      w_misaligned = 1'b0;
      w_be_base    = 4'b1111;
      w_wdata_rep  = req_wdata_i;
      case (req_size_i)
         2'd0: begin
            w_be_base   = 4'b0001;
            w_wdata_rep = {4{req_wdata_i[7:0]}};
         end
         2'd1: begin
            w_misaligned = req_addr_i[0];
            w_be_base    = 4'b0011;
            w_wdata_rep  = {2{req_wdata_i[15:0]}};
         end
         2'd2: begin
            w_misaligned = (req_addr_i[1:0] != 2'b00);
         end
         default: begin
            w_misaligned = 1'b1;
         end
      endcase
   end

   assign w_store     = w_accept & ~w_misaligned & req_we_i;
   assign tcm_en_o    = w_accept & ~w_misaligned;
   assign tcm_we_o    = w_store;
   assign tcm_addr_o  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign tcm_be_o    = w_store ? (w_be_base << req_addr_i[1:0]) : 4'b0000;
   assign tcm_wdata_o = w_store ? w_wdata_rep : 32'd0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_inf_valid <= 1'b0;
      end else begin
         r_inf_valid <= w_accept;
         if (w_accept) begin
            r_inf_we   <= req_we_i;
            r_inf_size <= req_size_i;
            r_inf_uns  <= req_unsigned_i;
            r_inf_off  <= req_addr_i[1:0];
            r_inf_err  <= w_misaligned;
         end
      end
   end

   assign w_shifted = tcm_rdata_i >> {r_inf_off, 3'b000};

   always_comb begin
      w_load = w_shifted;
      case (r_inf_size)
         2'd0:    w_load = r_inf_uns ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'd1:    w_load = r_inf_uns ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
   end

   assign w_rsp_data = (r_inf_err | r_inf_we) ? 32'd0 : w_load;
   assign w_push     = r_inf_valid;

   assign w_wr_nxt = (r_wr == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr + 1'b1;
   assign w_rd_nxt = (r_rd == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= w_wr_nxt;
         end
         if (w_pop) begin
            r_rd <= w_rd_nxt;
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_data[r_wr] <= w_rsp_data;
         r_err[r_wr]  <= r_inf_err;
      end
   end

   // Storage is not reset, so the head is gated to keep idle outputs at zero.
   assign rsp_valid_o = (r_count != '0);
   assign rsp_rdata_o = rsp_valid_o ? r_data[r_rd] : 32'd0;
   assign rsp_err_o   = rsp_valid_o & r_err[r_rd];

endmodule

`default_nettype wire

// File: tb/tb_tcm_lsu_bridge.sv
// ============================================================================
// Module      : tb_tcm_lsu_bridge
// Description : Scoreboard bench for tcm_lsu_bridge with a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcm_lsu_bridge;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          req_we_i;
   logic [1:0]    req_size_i;
   logic          req_unsigned_i;
   logic [31:0]   req_wdata_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [31:0]   rsp_rdata_o;
   logic          rsp_err_o;
   logic          tcm_en_o;
   logic [AW-1:0] tcm_addr_o;
   logic          tcm_we_o;
   logic [3:0]    tcm_be_o;
   logic [31:0]   tcm_wdata_o;
   logic [31:0]   tcm_rdata_i;

   tcm_lsu_bridge #(.ADDR_WIDTH(AW), .RSP_DEPTH(2)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .tcm_en_o       (tcm_en_o),
      .tcm_addr_o     (tcm_addr_o),
      .tcm_we_o       (tcm_we_o),
      .tcm_be_o       (tcm_be_o),
      .tcm_wdata_o    (tcm_wdata_o),
      .tcm_rdata_i    (tcm_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          rdy_mode = 0;
   logic [7:0]  ref_mem [0:32767];
   logic [31:0] tcm_mem [0:8191];

   always @(posedge clk) cyc <= cyc + 1;

   // TCM: synchronous RAM, read data valid the cycle after the access
   always @(posedge clk) begin
      if (tcm_en_o) begin
         if (tcm_we_o) begin
            for (int i = 0; i < 4; i++)
               if (tcm_be_o[i]) tcm_mem[tcm_addr_o[AW-1:2]][8*i +: 8] <= tcm_wdata_o[8*i +: 8];
         end else begin
            tcm_rdata_i <= tcm_mem[tcm_addr_o[AW-1:2]];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_idle();
      chk("idle_tcm_ctrl", {26'd0, tcm_en_o, tcm_we_o, tcm_be_o}, 32'd0);
      chk("idle_tcm_wdata", tcm_wdata_o, 32'd0);
   endtask

   // Reference model: applied at the accept point, in request order
   task automatic issue(input logic [AW-1:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
      bit          mis;
      int          n;
      logic [31:0] v, ebe, ewd;
      exp_t        e;
      mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ebe = 32'd0;
      ewd = 32'd0;
      if (!mis && we) begin
         ebe = ((32'd1 << n) - 32'd1) << a[1:0];
         ewd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
      end
      chk("tcm_en", {31'd0, tcm_en_o}, {31'd0, !mis});
      if (!mis) chk("tcm_addr", {17'd0, tcm_addr_o}, {17'd0, a & 15'h7FFC});
      chk("tcm_we", {31'd0, tcm_we_o}, {31'd0, (!mis && we)});
      chk("tcm_be", {28'd0, tcm_be_o}, ebe);
      chk("tcm_wdata", tcm_wdata_o, ewd);
      e.acc  = cyc;
      e.err  = mis;
      e.data = 32'd0;
      if (!mis && we) begin
         for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else if (!mis) begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(a) + i]) << (8 * i);
         if (!uns && v[8*n-1] && n < 4) v |= ~((32'd1 << (8 * n)) - 32'd1);
         e.data = v;
      end
      sbq.push_back(e);
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
      req_addr_i     = a;
      req_we_i       = we;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_wdata_i    = wd;
      req_valid_i    = 1'b1;
   endtask

   // Called just after a negedge with the request already driven
   task automatic wait_accept(input logic [AW-1:0] a, input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] wd);
      bit done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         if (t > 0) @(negedge clk);
         #1;
         if (req_ready_o) begin
            issue(a, we, sz, uns, wd);
            done = 1;
         end else begin
            chk_idle();
         end
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
      @(negedge clk);
      drive(a, we, sz, uns, wd);
      wait_accept(a, we, sz, uns, wd);
   endtask

   task automatic drain();
      int t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(negedge clk);
         #3;
         t++;
      end
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 32'd0);
      @(negedge clk);
   endtask

   // Response-ready driver, updated mid-cycle
   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       rsp_ready_i = 1'b1;
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever a response is consumed
   initial begin : mon
      logic        held;
      logic [31:0] hd;
      logic        he;
      exp_t        e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_i) begin
            sbq.delete();
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
               chk("hold_data", rsp_rdata_o, hd);
               chk("hold_err", {31'd0, rsp_err_o}, {31'd0, he});
            end
            held = 1'b0;
            if (rsp_valid_o) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
               end else if (rsp_ready_i) begin
                  e = sbq.pop_front();
                  chk("rsp_data", rsp_rdata_o, e.data);
                  chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
                  chk("rsp_latency_min", {31'd0, (cyc - e.acc) >= 2}, 32'd1);
               end else begin
                  held = 1'b1;
                  hd   = rsp_rdata_o;
                  he   = rsp_err_o;
               end
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] ra;
      logic          rwe;
      logic [1:0]    rsz;
      logic          runs;
      logic [31:0]   rwd;

      rst_i          = 1'b1;
      req_valid_i    = 1'b0;
      req_addr_i     = '0;
      req_we_i       = 1'b0;
      req_size_i     = 2'd0;
      req_unsigned_i = 1'b0;
      req_wdata_i    = 32'd0;

      // Reset values
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
         chk("rst_rsp", {rsp_rdata_o[30:0], rsp_valid_o} | {31'd0, rsp_err_o}, 32'd0);
         chk("rst_rsp_data", rsp_rdata_o, 32'd0);
         chk("rst_tcm", {28'd0, tcm_en_o, tcm_we_o, tcm_be_o[1:0]} | {28'd0, tcm_be_o}, 32'd0);
      end
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

      // Word store then load with exact latency
      send(15'h100, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
      drain();
      send(15'h100, 1'b0, 2'd2, 1'b0, 32'd0);
      @(negedge clk);
      #1;
      chk("lat_t1_not_valid", {31'd0, rsp_valid_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("lat_t2_valid", {31'd0, rsp_valid_o}, 32'd1);
      drain();

      // Byte and half extraction
      send(15'h100, 1'b1, 2'd2, 1'b0, 32'h80FF7F01);
      send(15'h103, 1'b0, 2'd0, 1'b0, 32'd0);
      send(15'h103, 1'b0, 2'd0, 1'b1, 32'd0);
      send(15'h102, 1'b0, 2'd1, 1'b0, 32'd0);
      send(15'h100, 1'b0, 2'd1, 1'b1, 32'd0);
      send(15'h101, 1'b0, 2'd0, 1'b0, 32'd0);

      // Byte store with replication and lane enable
      send(15'h201, 1'b1, 2'd0, 1'b0, 32'h000000AB);

      // Misaligned word load followed by a legal load
      send(15'h102, 1'b0, 2'd2, 1'b0, 32'd0);
      send(15'h100, 1'b0, 2'd2, 1'b0, 32'd0);
      drain();

      // Backpressure: two credits, then stall until the first pop
      rdy_mode = 1;
      @(negedge clk);
      @(negedge clk);
      send(15'h100, 1'b0, 2'd2, 1'b0, 32'd0);
      send(15'h101, 1'b0, 2'd0, 1'b0, 32'd0);
      @(negedge clk);
      drive(15'h102, 1'b0, 2'd1, 1'b0, 32'd0);
      for (int t = 0; t < 5; t++) begin
         if (t > 0) @(negedge clk);
         #1;
         chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
         chk_idle();
      end
      rdy_mode = 0;
      @(negedge clk);
      #1;
      chk("bp_first_pop_ready", {31'd0, req_ready_o}, 32'd1);
      wait_accept(15'h102, 1'b0, 2'd1, 1'b0, 32'd0);
      send(15'h103, 1'b0, 2'd0, 1'b1, 32'd0);
      drain();

      // Reset with two responses pending
      rdy_mode = 1;
      @(negedge clk);
      @(negedge clk);
      send(15'h100, 1'b0, 2'd2, 1'b0, 32'd0);
      send(15'h102, 1'b0, 2'd1, 1'b1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pending_before_rst", {31'd0, rsp_valid_o}, 32'd1);
      rst_i    = 1'b1;
      rdy_mode = 0;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("midrst_ready_after", {31'd0, req_ready_o}, 32'd1);
      for (int t = 0; t < 4; t++) begin
         chk("midrst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
         @(negedge clk);
         #1;
      end

      // Randomized traffic over a pre-filled window
      for (int i = 0; i < 16; i++) send(15'(15'h100 + 4 * i), 1'b1, 2'd2, 1'b0, $urandom);
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         ra   = 15'(15'h100 + $urandom_range(0, 63));
         rwe  = ($urandom_range(0, 2) == 0);
         rsz  = 2'($urandom_range(0, 3));
         runs = 1'($urandom_range(0, 1));
         rwd  = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            #1;
            chk_idle();
         end
         send(ra, rwe, rsz, runs, rwd);
      end
      rdy_mode = 0;
      drain();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tcm_lsu_bridge.md
# tcm_lsu_bridge

Initiator-side bridge between a core load/store unit and a single tightly-coupled memory port. It accepts byte, halfword and word requests on a valid/ready channel and drives the TCM port: enable, word-aligned byte address, write enable, byte enables and write data. It captures the TCM read data one cycle after each access, then aligns and sign-extends it. Responses come back in request order on a valid/ready channel, with a credit-limited response buffer so that response backpressure never drops TCM data.

## Interface
- ADDR_WIDTH, 15, byte address width; 8192 words × 4 B.
- RSP_DEPTH, 2, response buffer entries; minimum 2.
- Data width fixed at 32 bits.

- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as a misaligned request.
- req_unsigned_i  in  1  zero-extend load result.
- req_wdata_i  in  32  store data, LSB-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  32  aligned and extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal-size request.
- tcm_en_o  out  1  TCM access enable.
- tcm_addr_o  out  ADDR_WIDTH  byte address with bits [1:0] forced to 0.
- tcm_we_o  out  1  TCM write enable.
- tcm_be_o  out  4  TCM byte enables.
- tcm_wdata_o  out  32  replicated store data.
- tcm_rdata_i  in  32  TCM read data, valid one cycle after the access.

## Operation
**Credits**
- used = in-flight stage valid + FIFO count.
- req_ready_o = !rst_i && (used − (rsp_valid_o && rsp_ready_i)) < RSP_DEPTH.
- req_ready_o therefore depends combinationally on rsp_ready_i.

**Misalignment**
- Half with addr[0] = 1 is misaligned.
- Word with addr[1:0] ≠ 0 is misaligned.
- Size 3 is treated as misaligned.

**Accept, legal request**
- tcm_en_o = 1 in the same cycle.
- tcm_we_o = req_we_i; tcm_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.

**Accept, misaligned request**
- tcm_en_o stays 0.
- The request still takes a credit and an in-flight slot, which preserves response order.

**Store byte enables and data**
- be = (1, 3, F for byte/half/word) << addr[1:0].
- tcm_wdata_o = byte replicated ×4, half replicated ×2, or word as-is.
- When no request is accepted, tcm_we_o, tcm_be_o and tcm_wdata_o = 0.

**In-flight stage**
- Registers {valid, we, size, unsigned, offset = addr[1:0], err} at the accept edge.
- In the following cycle, computes the response from tcm_rdata_i and pushes it into the FIFO at the end of that cycle.

**Load extraction**
- byte = rdata[8·off +: 8]; half = rdata[8·off +: 16]; word as-is.
- Sign-extended unless req_unsigned_i was set.

**Store and error responses**
- Stores: rdata = 0, err = 0.
- Errors: rdata = 0, err = 1.

**FIFO**
- RSP_DEPTH entries, in-order.
- Head drives rsp_valid_o, rsp_rdata_o and rsp_err_o.
- Push and pop may occur in the same cycle when full; the credit rule guarantees the FIFO never overflows.

**Reset**
- Mid-operation reset clears the in-flight valid bit and the FIFO, and discards pending responses.
- A TCM write already sampled by the TCM stays committed.

## Timing
**Reset values**
- rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
- req_ready_o = 0 while rst_i is high; it returns to 1 in the first cycle after reset.
- tcm_en_o = 0, tcm_we_o = 0, tcm_be_o = 0 during reset.

**Latency**
- Request accepted in cycle T: the TCM samples at the end of T, tcm_rdata_i is used in T+1, and rsp_valid_o = 1 in T+2.
- Minimum request-to-response latency is 2 cycles.

**Throughput**
- With rsp_ready_i held at 1, one request is accepted per cycle indefinitely at RSP_DEPTH = 2.

**Backpressure**
- With rsp_ready_i = 0, at most RSP_DEPTH requests are accepted.
- req_ready_o then stays 0 until a response pops.
- The first pop raises req_ready_o in the same cycle.

**Response hold**
- rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable until consumed.

**Request rules**
- Request fields are sampled only on the accept cycle.
- Withdrawing req_valid_i while req_ready_o = 0 is allowed.

## Test plan
- **Reset/stall rules:** hold rst_i for 3 cycles → all outputs match the reset values, req_ready_o = 0 throughout, and req_ready_o = 1 in the first cycle after deassertion; additionally apply reset while 2 responses are pending → no response emerges afterwards and req_ready_o = 1 the cycle after.
- **Store then load, word:** store 0xDEADBEEF to 0x100, then load 0x100 → tcm_be_o = F, tcm_addr_o = 0x100; load response 0xDEADBEEF, err = 0, arriving 2 cycles after accept.
- **Byte and half extraction:** stored word 0x80FF7F01; signed byte load from 0x103 → 0xFFFFFF80; unsigned byte load from 0x103 → 0x00000080; signed half load from 0x102 → 0xFFFF80FF.
- **Store byte at 0x201 with data 0xAB:** tcm_be_o = 2, tcm_wdata_o = 0xABABABAB, tcm_addr_o = 0x200.
- **Misaligned word load at 0x102, followed by a legal load:** tcm_en_o = 0 on the first accept; responses arrive in order as {err = 1, rdata = 0} then the legal data.
- **Backpressure:** rsp_ready_i = 0 with 4 back-to-back loads → exactly 2 accepted and req_ready_o = 0; release rsp_ready_i → responses arrive in order, the remaining 2 requests are accepted, and no data is lost or duplicated.
